// File: rtl/sine_pwm_dac_if.sv
// Sample stream from the sine generator into the PWM DAC output stage.
interface sine_pwm_dac_if #(
  parameter int unsigned DW = 16
);
  localparam int unsigned AMP_W = 2;

  logic [DW-1:0]    sample_in;
  logic             sample_valid;
  logic             sample_ready;
  logic [AMP_W-1:0] amp;

  modport master (
    output sample_in,
    output sample_valid,
    output amp,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  amp,
    output sample_ready
  );
endinterface

// File: rtl/sine_pwm_dac.sv
// Sine sample to PWM converter: attenuate, convert to offset binary, double-buffer
// the duty value and swap it in only on a PWM period boundary.
module sine_pwm_dac #(
  parameter int unsigned DW = 16,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  sine_pwm_dac_if.slave bus,
  output logic          pwm_out,
  output logic          period_start,
  output logic [PW-1:0] duty
);

  localparam logic [PW-1:0] CNT_LAST = '1;
  localparam logic [PW-1:0] DUTY_MID = {1'b1, {(PW-1){1'b0}}};

  logic [PW-1:0]        cnt;
  logic [PW-1:0]        pend;
  logic                 pend_full;
  logic [PW-1:0]        d_conv;
  logic signed [DW-1:0] s_shift;
  logic                 boundary;
  logic                 accept;

  // Attenuate by an arithmetic shift, then keep the top PW bits as offset binary.
  always_comb begin
    s_shift = $signed(bus.sample_in) >>> bus.amp;
    d_conv  = {~s_shift[DW-1], s_shift[DW-2:DW-PW]};
  end

  assign boundary         = (cnt == CNT_LAST);
  assign accept           = bus.sample_valid && !pend_full;
  assign bus.sample_ready = ~pend_full;

  // Free-running PWM period counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  // Pending/active duty double buffer; the active value only moves at a boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= '0;
      pend_full <= 1'b0;
      duty      <= DUTY_MID;
    end else if (accept) begin
      pend      <= d_conv;
      pend_full <= 1'b1;
    end else if (boundary && pend_full) begin
      duty      <= pend;
      pend_full <= 1'b0;
    end
  end

  // Registered PWM pin and period-start marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= (cnt < duty);
      period_start <= boundary;
    end
  end

endmodule

// File: tb/tb_sine_pwm_dac.sv
// Bench for sine_pwm_dac: scenario tasks checked against a queue-based reference model.
module tb_sine_pwm_dac;

  logic       clk;
  logic       rst;
  logic       pwm_out;
  logic       period_start;
  logic [7:0] duty;

  sine_pwm_dac_if #(.DW(16)) bus ();

  sine_pwm_dac #(.DW(16), .PW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty         (duty)
  );

  int total = 0;
  int bad   = 0;

  // reference model state: counter position, active duty, pending queue (depth 1)
  int         m_cnt;
  logic [7:0] m_duty;
  logic       m_pwm;
  logic       m_ps;
  logic [7:0] m_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int fdiv(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  // sample/2^amp rounded down, then divided by 256 rounded down, offset by mid-scale
  function automatic logic [7:0] conv(input logic [15:0] smp, input logic [1:0] a);
    int v;
    v = int'($signed(smp));
    v = fdiv(v, 1 << a);
    return 8'(fdiv(v, 256) + 128);
  endfunction

  function automatic logic m_rdy();
    return (m_q.size() == 0);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_duty = 8'd128;
    m_pwm  = 1'b0;
    m_ps   = 1'b0;
    m_q.delete();
  endtask

  // one clock edge of the reference behaviour, using the inputs seen at that edge
  task automatic model_step();
    m_pwm = (m_cnt < int'(m_duty));
    m_ps  = (m_cnt == 255);
    if (m_cnt == 255 && m_q.size() != 0) m_duty = m_q.pop_front();
    else if (bus.sample_valid && m_q.size() == 0) m_q.push_back(conv(bus.sample_in, bus.amp));
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (m_cnt != target && n < 300) begin
      tick();
      n++;
    end
    if (m_cnt != target) begin
      total++;
      bad++;
      $display("FAIL wait_cnt timeout got=%0d want=%0d", m_cnt, target);
    end
  endtask

  task automatic test_reset();
    int highs = 0;
    int pss = 0;
    rst = 1'b0;
    model_reset();
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    bus.amp = '0;
    repeat (3) tick();
    total++;
    if ({bus.sample_ready, duty, pwm_out, period_start} !== {1'b1, 8'd128, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b duty=%0d pwm=%b ps=%b want 1/128/0/0",
               bus.sample_ready, duty, pwm_out, period_start);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
      if (i < 255 && period_start === 1'b1) pss++;
      total++;
      if ({duty, pwm_out, period_start, bus.sample_ready} !== {m_duty, m_pwm, m_ps, m_rdy()}) begin
        bad++;
        $display("FAIL reset_cycle i=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 duty, pwm_out, period_start, bus.sample_ready, m_duty, m_pwm, m_ps, m_rdy());
      end
    end
    total++;
    if (highs !== 128) begin bad++; $display("FAIL reset_highs got=%0d want=128", highs); end
    total++;
    if (pss !== 0) begin bad++; $display("FAIL reset_period_start got=%0d want=0", pss); end
  endtask

  task automatic test_full_scale();
    int highs = 0;
    wait_cnt(10);
    bus.sample_in = 16'h7530;
    bus.amp = 2'd0;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    total++;
    if (bus.sample_ready !== 1'b0 || duty !== 8'd128) begin
      bad++;
      $display("FAIL fs_accept got rdy=%b duty=%0d want 0/128", bus.sample_ready, duty);
    end
    wait_cnt(0);
    total++;
    if (duty !== 8'd245 || period_start !== 1'b1) begin
      bad++;
      $display("FAIL fs_swap got duty=%0d ps=%b want 245/1", duty, period_start);
    end
    for (int i = 0; i < 256; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
      total++;
      if ({duty, pwm_out, period_start, bus.sample_ready} !== {m_duty, m_pwm, m_ps, m_rdy()}) begin
        bad++;
        $display("FAIL fs_cycle i=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 duty, pwm_out, period_start, bus.sample_ready, m_duty, m_pwm, m_ps, m_rdy());
      end
    end
    total++;
    if (highs !== 245) begin bad++; $display("FAIL fs_highs got=%0d want=245", highs); end
  endtask

  task automatic test_attenuated();
    int highs = 0;
    bus.sample_in = 16'h8AD0;
    bus.amp = 2'd2;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    bus.amp = 2'd0;
    bus.sample_in = 16'($urandom);
    total++;
    if (bus.sample_ready !== 1'b0) begin bad++; $display("FAIL att_accept got rdy=%b want 0", bus.sample_ready); end
    wait_cnt(0);
    total++;
    if (duty !== 8'd98) begin bad++; $display("FAIL att_duty got=%0d want=98", duty); end
    for (int i = 0; i < 256; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
    total++;
    if (highs !== 98 || duty !== 8'd98) begin
      bad++;
      $display("FAIL att_highs got highs=%0d duty=%0d want 98/98", highs, duty);
    end
  endtask

  task automatic test_back_to_back();
    int highs = 0;
    int n = 0;
    bus.sample_in = 16'h0000;
    bus.amp = 2'($urandom_range(0, 3));
    bus.sample_valid = 1'b1;
    tick();
    total++;
    if (bus.sample_ready !== 1'b0) begin bad++; $display("FAIL b2b_a_accept got rdy=%b want 0", bus.sample_ready); end
    bus.sample_in = 16'h8000;
    bus.amp = 2'd0;
    while (m_cnt != 0 && n < 300) begin
      tick();
      n++;
      total++;
      if ({duty, pwm_out, period_start, bus.sample_ready} !== {m_duty, m_pwm, m_ps, m_rdy()}) begin
        bad++;
        $display("FAIL b2b_hold n=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", n,
                 duty, pwm_out, period_start, bus.sample_ready, m_duty, m_pwm, m_ps, m_rdy());
      end
    end
    total++;
    if (duty !== 8'd128 || bus.sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_boundary got duty=%0d rdy=%b want 128/1", duty, bus.sample_ready);
    end
    tick();
    bus.sample_valid = 1'b0;
    total++;
    if (bus.sample_ready !== 1'b0 || duty !== 8'd128) begin
      bad++;
      $display("FAIL b2b_b_accept got rdy=%b duty=%0d want 0/128", bus.sample_ready, duty);
    end
    wait_cnt(0);
    total++;
    if (duty !== 8'd0) begin bad++; $display("FAIL b2b_b_duty got=%0d want=0", duty); end
    for (int i = 0; i < 256; i++) begin
      tick();
      if (pwm_out !== 1'b0) highs++;
    end
    total++;
    if (highs !== 0) begin bad++; $display("FAIL b2b_low_period got highs=%0d want=0", highs); end
  endtask

  task automatic test_collision();
    logic [15:0] v;
    logic [1:0]  a;
    logic [7:0]  exp_d;
    v = 16'($urandom);
    a = 2'($urandom_range(0, 3));
    exp_d = conv(v, a);
    wait_cnt(255);
    bus.sample_in = v;
    bus.amp = a;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    total++;
    if (bus.sample_ready !== 1'b0 || duty !== 8'd0 || period_start !== 1'b1) begin
      bad++;
      $display("FAIL coll_accept got rdy=%b duty=%0d ps=%b want 0/0/1",
               bus.sample_ready, duty, period_start);
    end
    tick();
    wait_cnt(0);
    total++;
    if (duty !== exp_d) begin bad++; $display("FAIL coll_apply got=%0d want=%0d", duty, exp_d); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2048; i++) begin
      bus.sample_valid = ($urandom_range(0, 2) == 0);
      bus.sample_in = 16'($urandom);
      bus.amp = 2'($urandom_range(0, 3));
      tick();
      total++;
      if ({duty, pwm_out, period_start, bus.sample_ready} !== {m_duty, m_pwm, m_ps, m_rdy()}) begin
        bad++;
        $display("FAIL rand_cycle i=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 duty, pwm_out, period_start, bus.sample_ready, m_duty, m_pwm, m_ps, m_rdy());
      end
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int highs = 0;
    int n = 0;
    logic was;
    bus.sample_in = 16'h7530;
    bus.amp = 2'd0;
    bus.sample_valid = 1'b1;
    do begin
      was = m_rdy();
      tick();
      n++;
    end while (!was && n < 600);
    bus.sample_valid = 1'b0;
    tick();
    wait_cnt(0);
    total++;
    if (duty !== 8'd245) begin bad++; $display("FAIL rm_setup got duty=%0d want=245", duty); end
    bus.sample_in = 16'h8000;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    wait_cnt(100);
    total++;
    if (bus.sample_ready !== 1'b0 || pwm_out !== 1'b1) begin
      bad++;
      $display("FAIL rm_before got rdy=%b pwm=%b want 0/1", bus.sample_ready, pwm_out);
    end
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if ({bus.sample_ready, duty, pwm_out, period_start} !== {1'b1, 8'd128, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rm_async got rdy=%b duty=%0d pwm=%b ps=%b want 1/128/0/0",
               bus.sample_ready, duty, pwm_out, period_start);
    end
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
      total++;
      if ({duty, pwm_out, period_start, bus.sample_ready} !== {m_duty, m_pwm, m_ps, m_rdy()}) begin
        bad++;
        $display("FAIL rm_cycle i=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 duty, pwm_out, period_start, bus.sample_ready, m_duty, m_pwm, m_ps, m_rdy());
      end
    end
    total++;
    if (highs !== 128 || duty !== 8'd128) begin
      bad++;
      $display("FAIL rm_after got highs=%0d duty=%0d want 128/128", highs, duty);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_attenuated();
    test_back_to_back();
    test_collision();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sine_pwm_dac.md
# sine_pwm_dac

Output stage of the function generator. It consumes the 16-bit signed sine samples from the sine generator, applies a selectable power-of-two attenuation, and converts each sample to an 8-bit offset-binary duty value. It drives a single-bit PWM pin that the board's RC filter turns back into an analog waveform. Samples are double-buffered, so the duty value only changes on a PWM period boundary.

## Interface
Parameters:
- `DW`, default 16: input sample width (signed, two's complement).
- `PW`, default 8: PWM resolution in bits; period = 2^PW clocks.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `sample_in`, input, DW: signed sample from the sine generator.
- `sample_valid`, input, 1: `sample_in` is valid this cycle.
- `sample_ready`, output, 1: pending buffer is empty; a sample can be accepted.
- `amp`, input, 2: attenuation, sample arithmetically shifted right by `amp` (0..3).
- `pwm_out`, output, 1: registered PWM output.
- `period_start`, output, 1: one-cycle pulse marking the first cycle of each PWM period.
- `duty`, output, PW: duty value currently in use (active register).

## Operation
- Conversion happens at capture:
  - `s = sample_in >>> amp`, arithmetic shift with sign extension.
  - `d = {~s[DW-1], s[DW-2:DW-PW]}` (top PW bits with MSB inverted, giving offset binary).
  - Values: 0 → 128; 0x7FFF → 255; 0x8000 → 0.
- Pending buffer is one entry: `pend` (PW bits) plus flag `pend_full`.
  - `sample_ready = ~pend_full`, combinational from the register.
  - Handshake: a sample is accepted on an edge where `sample_valid && sample_ready`. On accept, `pend <= d` and `pend_full <= 1`.
  - `amp` is sampled at accept time only. Changing `amp` later does not alter a buffered or active value.
- PWM counter `cnt` (PW bits) is free-running, increments every clock, and wraps from 2^PW-1 to 0.
- Period boundary is the edge on which `cnt == 2^PW-1`:
  - If `pend_full`: `duty <= pend` and `pend_full <= 0`.
  - Otherwise `duty` holds.
- Simultaneous events:
  - `pend_full=1` at the boundary: ready is 0, so nothing is accepted that cycle. Ready rises the following cycle.
  - `pend_full=0` at the boundary with `sample_valid=1`: the sample is accepted into `pend`. It is not forwarded to `duty` until the next boundary.
- `pwm_out <= (cnt < duty)`, evaluated with pre-edge values.
  - Per period: high for exactly `duty` clocks and low for 2^PW−`duty` clocks.
  - `duty=0` gives a constant low output. Full-on is not reachable; the maximum is 255/256.
- `period_start <= (cnt == 2^PW-1)`, so it is high during the cycle where `cnt == 0`.
- No input is ever dropped. The upstream must hold `sample_valid` and `sample_in` until it is accepted.

## Timing
- Reset values, applied asynchronously while `rst` is low:

  | Signal | Reset value |
  |---|---|
  | `cnt` | 0 |
  | `duty` | 128 (mid-scale) |
  | `pend` | 0 |
  | `pend_full` | 0 (`sample_ready` = 1) |
  | `pwm_out` | 0 |
  | `period_start` | 0 |

- Reset mid-period discards both the pending and active samples. After release, the counter restarts at 0.
- First period after reset:
  - `period_start` does not pulse.
  - `pwm_out` is high for cycles 1..128 relative to the first clock edge after release.
- Accept-to-duty latency: from the accept edge up to the next boundary edge, between 1 and 2^PW clocks.
- `pwm_out` reflects a new `duty` starting 1 clock after the boundary edge, which is the cycle `period_start` is high.
- Throughput: at most one sample per PWM period (256 clocks). The upstream is back-pressured through `sample_ready`.

## Test plan
1. **Reset:** hold `rst=0` for 3 clocks, then release. Required: `sample_ready=1`, `duty=128`, `pwm_out` high for 128 of the first 256 cycles, `period_start` low during that period.
2. **Full-scale positive:** `sample_in=0x7530` (30000), `amp=0`, accepted at `cnt=10`. Required: `duty=245` from the next boundary; `pwm_out` high for 245 cycles and low for 11 in that period.
3. **Attenuated negative:** `sample_in=0x8AD0` (−30000), `amp=2`. Required: shifted value 0xE2B4 and `duty=98` after the boundary. Also change `amp` to 0 after accept; required: `duty` is still 98.
4. **Back-pressure:** hold `sample_valid=1` with samples A=0x0000 then B=0x8000.
   - A is accepted immediately and `sample_ready` drops.
   - B is accepted the cycle after the boundary.
   - Required: `duty` is 128 then 0; `pwm_out` stays constant low through the B period.
5. **Boundary collision:** present a sample exactly at `cnt=255` with `pend_full=0`. Required: accepted that edge, `duty` unchanged, applied one full period later.
6. **Reset mid-period:** with `pend_full=1` and `duty=245`, assert `rst` at `cnt=100`. Required: the full reset state is restored immediately and the pending sample is lost.
